// File: rtl/lvl_state_table.sv
// Per-level decision state table with backtrack-level search and indexed load/read port.
// Optional build macro LVL_STATE_FAST_FIND_EN: single-cycle combinational search instead of the scan.
module lvl_state_table #(
   parameter int NUM_LVLS         = 16,
   parameter int WIDTH_LVL        = 16,
   parameter int WIDTH_BIN        = 10,
   parameter int WIDTH_LVL_STATES = 11
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        dcd_valid_i,
   input  logic [WIDTH_LVL-1:0]        cur_lvl_i,
   input  logic [WIDTH_BIN-1:0]        cur_bin_num_i,
   input  logic                        find_start_i,
   input  logic [WIDTH_LVL-1:0]        max_lvl_i,
   output logic                        find_busy_o,
   output logic                        find_done_o,
   output logic                        find_found_o,
   output logic [WIDTH_LVL-1:0]        bkt_lvl_o,
   output logic [WIDTH_BIN-1:0]        bkt_bin_o,
   input  logic                        apply_bkt_i,
   input  logic                        wr_en_i,
   input  logic [WIDTH_LVL-1:0]        wr_idx_i,
   input  logic [WIDTH_LVL_STATES-1:0] lvl_state_i,
   input  logic [WIDTH_LVL-1:0]        rd_idx_i,
   output logic [WIDTH_LVL_STATES-1:0] lvl_state_o
);
   // state  | meaning
   // S_IDLE | waiting for find_start_i; backtrack may be applied
   // S_SCAN | examining one level per cycle, walking down from the start level
   // S_DONE | result latched; find_done_o strobes for this cycle
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t                     r_state, w_state_nxt;
   logic [WIDTH_BIN-1:0]       r_dcd_bin [NUM_LVLS];
   logic [NUM_LVLS-1:0]        r_has_bkt;
   logic [WIDTH_LVL-1:0]       r_ptr, w_ptr_nxt, w_start_ptr;
   logic                       r_found;
   logic [WIDTH_LVL-1:0]       r_bkt_lvl;
   logic [WIDTH_BIN-1:0]       r_bkt_bin;
   logic [WIDTH_LVL_STATES-1:0] r_rd_data, w_rd_data;
   logic                       w_ld_res, w_res_found;
   logic [WIDTH_LVL-1:0]       w_res_lvl;
   logic [WIDTH_BIN-1:0]       w_res_bin;
   logic                       w_ptr_bkt;
   logic [WIDTH_BIN-1:0]       w_ptr_bin;
   logic                       w_apply;

   assign w_start_ptr = (max_lvl_i > WIDTH_LVL'(NUM_LVLS-1)) ? WIDTH_LVL'(NUM_LVLS-1) : max_lvl_i;
   assign w_apply     = apply_bkt_i && (r_state == S_IDLE) && r_found;

   always_comb begin
      w_ptr_bkt = 1'b0;
      w_ptr_bin = '0;
      w_rd_data = '0;
      for (int i = 0; i < NUM_LVLS; i++) begin
         if (r_ptr == WIDTH_LVL'(i)) begin
            w_ptr_bkt = r_has_bkt[i];
            w_ptr_bin = r_dcd_bin[i];
         end
         if (rd_idx_i == WIDTH_LVL'(i))
            w_rd_data = {r_dcd_bin[i], r_has_bkt[i]};
      end
   end

`ifdef LVL_STATE_FAST_FIND_EN
   logic                 w_fast_found;
   logic [WIDTH_LVL-1:0] w_fast_lvl;
   logic [WIDTH_BIN-1:0] w_fast_bin;

   // Ascending loop, so the highest qualifying level wins.
   always_comb begin
      w_fast_found = 1'b0;
      w_fast_lvl   = '0;
      w_fast_bin   = '0;
      for (int i = 1; i < NUM_LVLS; i++) begin
         if ((WIDTH_LVL'(i) <= w_start_ptr) && !r_has_bkt[i]) begin
            w_fast_found = 1'b1;
            w_fast_lvl   = WIDTH_LVL'(i);
            w_fast_bin   = r_dcd_bin[i];
         end
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_ld_res    = 1'b0;
      w_res_found = 1'b0;
      w_res_lvl   = '0;
      w_res_bin   = '0;
      case (r_state)
         S_IDLE: begin
            if (find_start_i) begin
               if (max_lvl_i == '0) begin
                  w_state_nxt = S_DONE;
                  w_ld_res    = 1'b1;
               end else begin
`ifdef LVL_STATE_FAST_FIND_EN
                  w_state_nxt = S_DONE;
                  w_ld_res    = 1'b1;
                  w_res_found = w_fast_found;
                  w_res_lvl   = w_fast_lvl;
                  w_res_bin   = w_fast_bin;
`else
                  w_state_nxt = S_SCAN;
                  w_ptr_nxt   = w_start_ptr;
`endif
               end
            end
         end
         S_SCAN: begin
            if (!w_ptr_bkt) begin
               w_state_nxt = S_DONE;
               w_ld_res    = 1'b1;
               w_res_found = 1'b1;
               w_res_lvl   = r_ptr;
               w_res_bin   = w_ptr_bin;
            end else if (r_ptr == WIDTH_LVL'(1)) begin
               w_state_nxt = S_DONE;
               w_ld_res    = 1'b1;
            end else begin
               w_ptr_nxt = r_ptr - WIDTH_LVL'(1);
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_found   <= 1'b0;
         r_bkt_lvl <= '0;
         r_bkt_bin <= '0;
         r_rd_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_rd_data <= w_rd_data;
         if (w_ld_res) begin
            r_found   <= w_res_found;
            r_bkt_lvl <= w_res_lvl;
            r_bkt_bin <= w_res_bin;
         end
      end
   end

   // Later assignments win: apply over decision over load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dcd_bin <= '{default: '0};
         r_has_bkt <= '0;
      end else begin
         for (int i = 0; i < NUM_LVLS; i++) begin
            if (wr_en_i && (wr_idx_i == WIDTH_LVL'(i))) begin
               r_dcd_bin[i] <= lvl_state_i[WIDTH_LVL_STATES-1:1];
               r_has_bkt[i] <= lvl_state_i[0];
            end
            if (dcd_valid_i && (cur_lvl_i == WIDTH_LVL'(i))) begin
               r_dcd_bin[i] <= cur_bin_num_i;
               r_has_bkt[i] <= 1'b0;
            end
            if (w_apply) begin
               if (WIDTH_LVL'(i) == r_bkt_lvl) begin
                  r_has_bkt[i] <= 1'b1;
               end else if (WIDTH_LVL'(i) > r_bkt_lvl) begin
                  r_dcd_bin[i] <= '0;
                  r_has_bkt[i] <= 1'b0;
               end
            end
         end
      end
   end

   assign find_busy_o  = (r_state == S_SCAN);
   assign find_done_o  = (r_state == S_DONE);
   assign find_found_o = r_found;
   assign bkt_lvl_o    = r_bkt_lvl;
   assign bkt_bin_o    = r_bkt_bin;
   assign lvl_state_o  = r_rd_data;

endmodule

// File: tb/tb_lvl_state_table.sv
// Directed bench for lvl_state_table: find-level vector table plus hand sequences for
// backtrack apply, write conflicts, read latency and reset during a search.
module tb_lvl_state_table;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dcd_valid_i = 1'b0;
   logic [15:0] cur_lvl_i = '0;
   logic [9:0]  cur_bin_num_i = '0;
   logic        find_start_i = 1'b0;
   logic [15:0] max_lvl_i = '0;
   logic        find_busy_o, find_done_o, find_found_o;
   logic [15:0] bkt_lvl_o;
   logic [9:0]  bkt_bin_o;
   logic        apply_bkt_i = 1'b0;
   logic        wr_en_i = 1'b0;
   logic [15:0] wr_idx_i = '0;
   logic [10:0] lvl_state_i = '0;
   logic [15:0] rd_idx_i = '0;
   logic [10:0] lvl_state_o;

   int n_chk = 0;
   int n_err = 0;

   lvl_state_table dut (
      .clk(clk), .rst(rst),
      .dcd_valid_i(dcd_valid_i), .cur_lvl_i(cur_lvl_i), .cur_bin_num_i(cur_bin_num_i),
      .find_start_i(find_start_i), .max_lvl_i(max_lvl_i),
      .find_busy_o(find_busy_o), .find_done_o(find_done_o), .find_found_o(find_found_o),
      .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o), .apply_bkt_i(apply_bkt_i),
      .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .lvl_state_i(lvl_state_i),
      .rd_idx_i(rd_idx_i), .lvl_state_o(lvl_state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] mask;
      logic [15:0] mx;
      logic        found;
      logic [15:0] lvl;
      logic [9:0]  bin;
      int          n;
   } vec_t;

   typedef struct {
      logic [15:0] idx;
      logic [10:0] st;
   } rdv_t;

   vec_t vecs[8];
   rdv_t rdvs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [15:0] idx, input logic [10:0] st);
      wr_en_i = 1'b1; wr_idx_i = idx; lvl_state_i = st;
      tick();
      wr_en_i = 1'b0;
   endtask

   task automatic dcd(input logic [15:0] lvl, input logic [9:0] bin);
      dcd_valid_i = 1'b1; cur_lvl_i = lvl; cur_bin_num_i = bin;
      tick();
      dcd_valid_i = 1'b0;
   endtask

   task automatic rd(input logic [15:0] idx, output logic [10:0] st);
      rd_idx_i = idx;
      tick();
      st = lvl_state_o;
   endtask

   task automatic load_levels(input logic [15:0] mask);
      for (int i = 0; i < 16; i++)
         wr(16'(i), {(i == 0) ? 10'd0 : 10'(100 + i), mask[i]});
   endtask

   task automatic find(input logic [15:0] mx, output int lat, output int busy_cnt);
      find_start_i = 1'b1; max_lvl_i = mx;
      tick();
      find_start_i = 1'b0;
      lat = 1; busy_cnt = 0;
      while (!find_done_o && lat < 40) begin
         if (find_busy_o) busy_cnt++;
         tick();
         lat++;
      end
   endtask

   function automatic int exp_lat(input int n);
`ifdef LVL_STATE_FAST_FIND_EN
      return 1;
`else
      return n + 1;
`endif
   endfunction

   function automatic int exp_busy(input int n);
`ifdef LVL_STATE_FAST_FIND_EN
      return 0;
`else
      return n;
`endif
   endfunction

   initial begin
      int lat, busy, dcnt;
      logic [10:0] st;

      vecs[0] = '{16'h0020, 16'd5,  1'b1, 16'd4,  10'd104, 2};
      vecs[1] = '{16'h000E, 16'd3,  1'b0, 16'd0,  10'd0,   3};
      vecs[2] = '{16'h0000, 16'd40, 1'b1, 16'd15, 10'd115, 1};
      vecs[3] = '{16'hE000, 16'd40, 1'b1, 16'd12, 10'd112, 4};
      vecs[4] = '{16'h0000, 16'd0,  1'b0, 16'd0,  10'd0,   0};
      vecs[5] = '{16'hFFFE, 16'd15, 1'b0, 16'd0,  10'd0,   15};
      vecs[6] = '{16'h00FC, 16'd7,  1'b1, 16'd1,  10'd101, 7};
      vecs[7] = '{16'h0000, 16'd1,  1'b1, 16'd1,  10'd101, 1};

      rdvs[0] = '{16'd4,  {10'd12, 1'b1}};
      rdvs[1] = '{16'd3,  {10'd9,  1'b0}};
      rdvs[2] = '{16'd5,  11'd0};
      rdvs[3] = '{16'd10, 11'd0};
      rdvs[4] = '{16'd15, 11'd0};
      rdvs[5] = '{16'd1,  {10'd3,  1'b0}};
      rdvs[6] = '{16'd20, 11'd0};

      tick(); tick();
      rst = 1'b0;
      rd_idx_i = 16'd3;
      chk("rst_busy",  find_busy_o,  0);
      chk("rst_done",  find_done_o,  0);
      chk("rst_found", find_found_o, 0);
      chk("rst_lvl",   bkt_lvl_o,    0);
      chk("rst_bin",   bkt_bin_o,    0);
      chk("rst_rd",    lvl_state_o,  0);

      // Basic decision, search and backtrack flow.
      dcd(16'd1, 10'd3); dcd(16'd2, 10'd7); dcd(16'd3, 10'd9);
      dcd(16'd4, 10'd12); dcd(16'd5, 10'd20);
      wr(16'd5, {10'd20, 1'b1});
      find(16'd5, lat, busy);
      chk("s1_lat",   lat,          exp_lat(2));
      chk("s1_busy",  busy,         exp_busy(2));
      chk("s1_found", find_found_o, 1);
      chk("s1_lvl",   bkt_lvl_o,    4);
      chk("s1_bin",   bkt_bin_o,    12);
      tick();
      apply_bkt_i = 1'b1;
      tick();
      apply_bkt_i = 1'b0;
      for (int k = 0; k < 7; k++) begin
         rd(rdvs[k].idx, st);
         chk($sformatf("apply_rd%0d", rdvs[k].idx), st, rdvs[k].st);
      end

      // Apply must be ignored when the held result is "not found".
      wr(16'd6, {10'd33, 1'b0});
      find(16'd0, lat, busy);
      chk("m0_lat",   lat,          1);
      chk("m0_found", find_found_o, 0);
      tick();
      apply_bkt_i = 1'b1;
      tick();
      apply_bkt_i = 1'b0;
      rd(16'd6, st);
      chk("noapply_rd6", st, {10'd33, 1'b0});

      for (int v = 0; v < 8; v++) begin
         load_levels(vecs[v].mask);
         find(vecs[v].mx, lat, busy);
         chk($sformatf("v%0d_lat", v),   lat,          exp_lat(vecs[v].n));
         chk($sformatf("v%0d_busy", v),  busy,         exp_busy(vecs[v].n));
         chk($sformatf("v%0d_found", v), find_found_o, vecs[v].found);
         chk($sformatf("v%0d_lvl", v),   bkt_lvl_o,    vecs[v].lvl);
         chk($sformatf("v%0d_bin", v),   bkt_bin_o,    vecs[v].bin);
         tick();
         chk($sformatf("v%0d_done_1cyc", v), find_done_o, 0);
      end

      // Decision beats load on the same level; same-cycle write reads old data.
      dcd_valid_i = 1'b1; cur_lvl_i = 16'd2; cur_bin_num_i = 10'd6;
      wr_en_i = 1'b1; wr_idx_i = 16'd2; lvl_state_i = {10'd1, 1'b1};
      tick();
      dcd_valid_i = 1'b0; wr_en_i = 1'b0;
      rd(16'd2, st);
      chk("conflict_rd2", st, {10'd6, 1'b0});
      wr(16'd2, 11'h155);
      chk("rd_old_val", lvl_state_o, {10'd6, 1'b0});
      tick();
      chk("rd_new_val", lvl_state_o, 11'h155);

      // A second start during the search must not restart it.
      load_levels(16'h000C);
      find_start_i = 1'b1; max_lvl_i = 16'd3;
      tick();
      lat = 1;
      while (!find_done_o && lat < 40) begin
         find_start_i = (lat == 1);
         max_lvl_i = 16'd1;
         tick();
         lat++;
      end
      find_start_i = 1'b0;
      chk("restart_lat", lat,       exp_lat(3));
      chk("restart_lvl", bkt_lvl_o, 1);
      chk("restart_bin", bkt_bin_o, 101);

      // Reset during a five-level search.
      tick();
      load_levels(16'h003E);
      rd_idx_i = 16'd3;
      find_start_i = 1'b1; max_lvl_i = 16'd5;
      tick();
      find_start_i = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (find_done_o || find_busy_o) dcnt++;
         tick();
      end
      chk("rstmid_done", dcnt,         0);
      chk("rstmid_found", find_found_o, 0);
      chk("rstmid_lvl",  bkt_lvl_o,    0);
      chk("rstmid_bin",  bkt_bin_o,    0);
      chk("rstmid_rd3",  lvl_state_o,  0);
      find(16'd5, lat, busy);
      chk("after_rst_lat",   lat,          exp_lat(1));
      chk("after_rst_found", find_found_o, 1);
      chk("after_rst_lvl",   bkt_lvl_o,    5);
      chk("after_rst_bin",   bkt_bin_o,    0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
